diamond_df_ctrl: RTL and testbench

Dataflow region controller for the four-process diamond (funcA → funcB/funcC → funcD over channels c1..c4). It sequences each process's ap_start/ap_continue handshake from per-channel token counts, so no process starts without input data and no process retires without output space. It also derives the region-level ap_ctrl_hs handshake. It sits between the top-level control port and the four process instances, replacing hard-wired start/continue glue.

---
 rtl/diamond_df_ctrl.sv | 133 +++++++++++++
 tb/tb_diamond_df_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/diamond_df_ctrl.sv
// diamond_df_ctrl: token-counting start/continue sequencer for the funcA -> funcB/funcC -> funcD dataflow diamond
// Ports: ap_clk/ap_rst_n (async active-low reset); ap_start/ap_ready/ap_done/ap_idle region ap_ctrl_hs;
//   {a,b,c,d}_start/_ready/_done/_continue per-process handshakes; c1_cnt..c4_cnt channel occupancy.
// Define DIAMOND_DF_STALL_CNT_EN to add saturating 32-bit {a,b,c,d}_stall_cnt outputs.
module diamond_df_ctrl #(
  parameter int CH_DEPTH = 2,
  parameter int CNT_W    = $clog2(CH_DEPTH + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             a_start,
  output logic             b_start,
  output logic             c_start,
  output logic             d_start,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  input  logic             a_done,
  input  logic             b_done,
  input  logic             c_done,
  input  logic             d_done,
  output logic             a_continue,
  output logic             b_continue,
  output logic             c_continue,
  output logic             d_continue,
  output logic [CNT_W-1:0] c1_cnt,
  output logic [CNT_W-1:0] c2_cnt,
  output logic [CNT_W-1:0] c3_cnt,
  output logic [CNT_W-1:0] c4_cnt
`ifdef DIAMOND_DF_STALL_CNT_EN
  ,
  output logic [31:0]      a_stall_cnt,
  output logic [31:0]      b_stall_cnt,
  output logic [31:0]      c_stall_cnt,
  output logic [31:0]      d_stall_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CH_DEPTH);

  logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [3:0][1:0]  st_q, st_d;
  logic [3:0]       go, rdy, dn, ct, fire, prod;

  // Simultaneous produce and consume on one channel cancel out.
  function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] c, input logic inc, input logic dec);
    return (inc && !dec) ? c + 1'b1 : (dec && !inc) ? c - 1'b1 : c;
  endfunction

  // Starts and continues look only at registered counters: no done->start path, glitch-free continue.
  assign a_start    = ap_start;
  assign b_start    = c1_q != '0;
  assign c_start    = c2_q != '0;
  assign d_start    = (c3_q != '0) && (c4_q != '0);
  assign a_continue = (c1_q < FULL) && (c2_q < FULL);
  assign b_continue = c3_q < FULL;
  assign c_continue = c4_q < FULL;
  assign d_continue = 1'b1;

  assign go   = {d_start, c_start, b_start, a_start};
  assign rdy  = {d_ready, c_ready, b_ready, a_ready};
  assign dn   = {d_done, c_done, b_done, a_done};
  assign ct   = {d_continue, c_continue, b_continue, a_continue};
  assign fire = go & rdy;
  assign prod = dn & ct;

  assign c1_d = nxt(c1_q, prod[0], fire[1]);
  assign c2_d = nxt(c2_q, prod[0], fire[2]);
  assign c3_d = nxt(c3_q, prod[1], fire[3]);
  assign c4_d = nxt(c4_q, prod[2], fire[3]);

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < 4; i++)
      st_d[i] = (st_q[i] == IDLE) ? (fire[i] ? RUN : IDLE)
              : (st_q[i] == RUN)  ? (!dn[i] ? RUN : !ct[i] ? HOLD : fire[i] ? RUN : IDLE)
              : (ct[i] ? IDLE : HOLD);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
      c4_q <= '0;
      st_q <= '0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
      c3_q <= c3_d;
      c4_q <= c4_d;
      st_q <= st_d;
    end
  end

  assign c1_cnt   = c1_q;
  assign c2_cnt   = c2_q;
  assign c3_cnt   = c3_q;
  assign c4_cnt   = c4_q;
  assign ap_ready = a_ready & ap_start;
  assign ap_done  = d_done;
  assign ap_idle  = !ap_start && (st_q == '0) && (c1_q == '0) && (c2_q == '0) && (c3_q == '0) && (c4_q == '0);

`ifdef DIAMOND_DF_STALL_CNT_EN
  logic [3:0][31:0] stall_q, stall_d;
  logic [3:0]       stall;

  assign stall = (go & ~rdy) | (dn & ~ct);

  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < 4; i++)
      stall_d[i] = (stall[i] && stall_q[i] != '1) ? stall_q[i] + 32'd1 : stall_q[i];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign a_stall_cnt = stall_q[0];
  assign b_stall_cnt = stall_q[1];
  assign c_stall_cnt = stall_q[2];
  assign d_stall_cnt = stall_q[3];
`endif
endmodule

// File: tb/tb_diamond_df_ctrl.sv
// tb_diamond_df_ctrl: directed self-checking bench for diamond_df_ctrl with CH_DEPTH=2
module tb_diamond_df_ctrl;
  localparam int CW = 2;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0;
  logic ap_ready, ap_done, ap_idle;
  logic a_start, b_start, c_start, d_start;
  logic a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;
  logic a_done = 1'b0, b_done = 1'b0, c_done = 1'b0, d_done = 1'b0;
  logic a_continue, b_continue, c_continue, d_continue;
  logic [CW-1:0] c1_cnt, c2_cnt, c3_cnt, c4_cnt;
`ifdef DIAMOND_DF_STALL_CNT_EN
  logic [31:0] a_stall_cnt, b_stall_cnt, c_stall_cnt, d_stall_cnt;
`endif
  int total = 0, bad = 0;

  diamond_df_ctrl #(.CH_DEPTH(2)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .a_start(a_start), .b_start(b_start), .c_start(c_start), .d_start(d_start),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .a_done(a_done), .b_done(b_done), .c_done(c_done), .d_done(d_done),
    .a_continue(a_continue), .b_continue(b_continue), .c_continue(c_continue), .d_continue(d_continue),
    .c1_cnt(c1_cnt), .c2_cnt(c2_cnt), .c3_cnt(c3_cnt), .c4_cnt(c4_cnt)
`ifdef DIAMOND_DF_STALL_CNT_EN
    ,
    .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt), .c_stall_cnt(c_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Apply {ready a..d, done a..d} for the coming edge; values stay applied until the next drive/clr.
  task automatic drive(input logic ar, br, cr, dr, ad, bd, cd, dd);
    {a_ready, b_ready, c_ready, d_ready, a_done, b_done, c_done, d_done} = {ar, br, cr, dr, ad, bd, cd, dd};
    tick();
  endtask

  task automatic clr();
    {a_ready, b_ready, c_ready, d_ready, a_done, b_done, c_done, d_done} = '0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    clr();
    total++; if (c1_cnt !== 2'd1) begin bad++; $display("FAIL rst_pre_c1 got=%0d exp=1", c1_cnt); end
    total++; if (b_start !== 1'b1) begin bad++; $display("FAIL rst_pre_bstart got=%0b exp=1", b_start); end
    #2;
    ap_rst_n = 1'b0;
    #1;
    total++; if ({c1_cnt, c2_cnt, c3_cnt, c4_cnt} !== 8'h00) begin bad++; $display("FAIL rst_async_cnts got=%h exp=00", {c1_cnt, c2_cnt, c3_cnt, c4_cnt}); end
    total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0b exp=1", ap_idle); end
    total++; if ({b_start, c_start, d_start} !== 3'b000) begin bad++; $display("FAIL rst_starts got=%b exp=000", {b_start, c_start, d_start}); end
    total++; if ({a_continue, b_continue, c_continue, d_continue} !== 4'b1111) begin bad++; $display("FAIL rst_conts got=%b exp=1111", {a_continue, b_continue, c_continue, d_continue}); end
    tick();
    ap_rst_n = 1'b1;
    ap_start = 1'b1;
    #1;
    total++; if ({a_start, ap_idle} !== 2'b10) begin bad++; $display("FAIL rst_astart_idle got=%b exp=10", {a_start, ap_idle}); end
    ap_start = 1'b0;
  endtask

  task automatic test_single();
    ap_start = 1'b1;
    a_ready = 1'b1;
    #1;
    total++; if ({ap_ready, a_start} !== 2'b11) begin bad++; $display("FAIL single_apready got=%b exp=11", {ap_ready, a_start}); end
    tick();
    ap_start = 1'b0;
    a_ready = 1'b0;
    #1;
    total++; if (ap_idle !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b exp=0", ap_idle); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    a_done = 1'b1;
    #1;
    total++; if ({b_start, c1_cnt} !== 3'b000) begin bad++; $display("FAIL single_nocomb got=%b exp=000", {b_start, c1_cnt}); end
    tick();
    total++; if ({c1_cnt, c2_cnt} !== 4'b0101) begin bad++; $display("FAIL single_c12_up got=%b exp=0101", {c1_cnt, c2_cnt}); end
    total++; if ({b_start, c_start} !== 2'b11) begin bad++; $display("FAIL single_bc_start got=%b exp=11", {b_start, c_start}); end
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    total++; if ({c1_cnt, c2_cnt, c3_cnt} !== 6'd0) begin bad++; $display("FAIL single_c12_down got=%b exp=000000", {c1_cnt, c2_cnt, c3_cnt}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    total++; if ({c3_cnt, c4_cnt, d_start} !== 5'b01011) begin bad++; $display("FAIL single_c34_up got=%b exp=01011", {c3_cnt, c4_cnt, d_start}); end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    total++; if ({c3_cnt, c4_cnt, d_start, ap_idle, ap_done} !== 7'b0) begin bad++; $display("FAIL single_c34_down got=%b exp=0000000", {c3_cnt, c4_cnt, d_start, ap_idle, ap_done}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    d_done = 1'b1;
    #1;
    total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL single_apdone got=%0b exp=1", ap_done); end
    tick();
    d_done = 1'b0;
    #1;
    total++; if ({ap_done, ap_idle} !== 2'b01) begin bad++; $display("FAIL single_end got=%b exp=01", {ap_done, ap_idle}); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
    end
    total++; if ({c3_cnt, c4_cnt} !== 4'b1010) begin bad++; $display("FAIL bp_full got=%b exp=1010", {c3_cnt, c4_cnt}); end
    total++; if ({b_continue, c_continue, d_start} !== 3'b001) begin bad++; $display("FAIL bp_conts got=%b exp=001", {b_continue, c_continue, d_start}); end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    total++; if (dut.st_q[1] !== 2'd2) begin bad++; $display("FAIL bp_hold got=%0d exp=2", dut.st_q[1]); end
    total++; if ({c3_cnt, b_continue} !== 3'b100) begin bad++; $display("FAIL bp_hold_c3 got=%b exp=100", {c3_cnt, b_continue}); end
    drive(0, 0, 0, 1, 0, 1, 1, 0);
    total++; if ({c3_cnt, b_continue, c_continue} !== 4'b0111) begin bad++; $display("FAIL bp_free got=%b exp=0111", {c3_cnt, b_continue, c_continue}); end
    total++; if (dut.st_q[1] !== 2'd2) begin bad++; $display("FAIL bp_still_hold got=%0d exp=2", dut.st_q[1]); end
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    total++; if ({c3_cnt, c4_cnt} !== 4'b1010) begin bad++; $display("FAIL bp_retire got=%b exp=1010", {c3_cnt, c4_cnt}); end
    total++; if (dut.st_q[1] !== 2'd0) begin bad++; $display("FAIL bp_b_idle got=%0d exp=0", dut.st_q[1]); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    clr();
    #1;
    total++; if ({c3_cnt, c4_cnt, ap_idle} !== 5'b00001) begin bad++; $display("FAIL bp_drained got=%b exp=00001", {c3_cnt, c4_cnt, ap_idle}); end
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    total++; if (c1_cnt !== 2'd1) begin bad++; $display("FAIL sim_pre_c1 got=%0d exp=1", c1_cnt); end
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    total++; if ({c1_cnt, c2_cnt} !== 4'b0110) begin bad++; $display("FAIL sim_c1_c2 got=%b exp=0110", {c1_cnt, c2_cnt}); end
    total++; if ({a_continue, b_start} !== 2'b01) begin bad++; $display("FAIL sim_acont got=%b exp=01", {a_continue, b_start}); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    total++; if ({c1_cnt, c3_cnt} !== 4'b0001) begin bad++; $display("FAIL b2b_cnts got=%b exp=0001", {c1_cnt, c3_cnt}); end
    total++; if (dut.st_q[1] !== 2'd1) begin bad++; $display("FAIL b2b_run got=%0d exp=1", dut.st_q[1]); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if ({c1_cnt, c3_cnt} !== 4'b1010) begin bad++; $display("FAIL mid_pre_cnts got=%b exp=1010", {c1_cnt, c3_cnt}); end
    total++; if (dut.st_q[1] !== 2'd2) begin bad++; $display("FAIL mid_pre_hold got=%0d exp=2", dut.st_q[1]); end
    clr();
    #2;
    ap_rst_n = 1'b0;
    #1;
    total++; if ({c1_cnt, c2_cnt, c3_cnt, c4_cnt} !== 8'h00) begin bad++; $display("FAIL mid_cnts got=%h exp=00", {c1_cnt, c2_cnt, c3_cnt, c4_cnt}); end
    total++; if (dut.st_q !== 8'h00) begin bad++; $display("FAIL mid_fsms got=%h exp=00", dut.st_q); end
    tick();
    ap_rst_n = 1'b1;
    test_single();
  endtask

`ifdef DIAMOND_DF_STALL_CNT_EN
  task automatic test_stall_cnt();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    ap_start = 1'b1;
    repeat (5) tick();
    ap_start = 1'b0;
    total++; if (a_stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_a got=%0d exp=5", a_stall_cnt); end
    total++; if ({b_stall_cnt, c_stall_cnt, d_stall_cnt} !== 96'd0) begin bad++; $display("FAIL stall_others got=%0d/%0d/%0d exp=0/0/0", b_stall_cnt, c_stall_cnt, d_stall_cnt); end
  endtask
`endif

  initial begin
    tick();
    tick();
    ap_rst_n = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef DIAMOND_DF_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
